// File: rtl/ahb_pkg.sv
// Purpose: shared AHB-Lite types and constants for the SRAM slave.
//   htrans_t        : HTRANS encodings
//   HSIZE_*         : transfer size codes (2**HSIZE bytes)
//   HRESP_*         : response encodings
//   ahb_slv_state_t : slave data-phase FSM states
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_t;

    // Low-address bits that must be zero for a transfer of the given size.
    function automatic logic [7:0] size_align_mask(input logic [2:0] hsize);
        return 8'((9'd1 << hsize) - 9'd1);
    endfunction

endpackage

// File: rtl/sram_be_array.sv
// Purpose: word-indexed SRAM with per-byte synchronous write enables and
//          combinational read.
// Ports:
//   clk      : write clock
//   i_we     : per-byte write enable (one bit per lane)
//   i_widx   : write word index
//   i_wdata  : write data (all lanes, masked by i_we)
//   i_ridx   : read word index
//   o_rdata  : read data, combinational from i_ridx
module sram_be_array #(
    parameter int unsigned IDX_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [IDX_WIDTH-1:0]    i_widx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [IDX_WIDTH-1:0]    i_ridx,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    // Contents survive reset; zero start value is for simulation only.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    // Byte-lane write
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (i_we[b]) begin
                r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ahb_sram_slave.sv
// Purpose: AHB-Lite SRAM slave with pipelined address/data phases, byte-lane
//          writes, programmable wait states and two-cycle ERROR responses.
// Ports:
//   clk, HRESETn         : clock, async active-low reset
//   HSEL, HADDR, HWRITE,
//   HSIZE, HTRANS, HREADY: address-phase inputs from decoder/mux
//   HWDATA               : write data (data phase)
//   HRDATA               : read data, zero outside a read data phase
//   HREADYOUT, HRESP     : slave response
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = ADDR_WIDTH - LB;
    localparam int unsigned OW = (LB == 0) ? 1 : LB;
    localparam int unsigned CW = 3;

    ahb_slv_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_wcnt, w_wcnt_nxt;
    logic [IW-1:0]  r_idx;
    logic [NB-1:0]  r_mask;
    logic           r_write;

    htrans_t         w_trans;
    logic            w_active;
    logic            w_can_accept;
    logic            w_accept;
    logic            w_oversize;
    logic            w_misalign;
    logic            w_err;
    logic [OW-1:0]   w_offset;
    logic [NB-1:0]   w_mask;
    logic [NB-1:0]   w_we;
    logic            w_rd_phase;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Address-phase decode
    assign w_trans      = htrans_t'(HTRANS);
    assign w_active     = (w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ);
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept     = HSEL & HREADY & w_active & w_can_accept;

    assign w_oversize = (HSIZE > 3'(LB));
    assign w_misalign = |(8'(HADDR) & size_align_mask(HSIZE));
    assign w_err      = w_oversize | w_misalign;

    assign w_offset = (LB == 0) ? '0 : HADDR[OW-1:0];

    // Lane mask: 2**HSIZE consecutive lanes starting at the byte offset
    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_mask[b] = (b >= 32'(w_offset)) &&
                        (b < (32'(w_offset) + (32'd1 << HSIZE)));
        end
    end

    // Address-phase register
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx   <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= HADDR[ADDR_WIDTH-1:LB];
            r_mask  <= w_mask;
            r_write <= HWRITE;
        end
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_wcnt_nxt  = CW'(WAIT_STATES);
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wcnt <= CW'(1)) begin
                    w_state_nxt = ST_DATA;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt  = r_wcnt - CW'(1);
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Writes commit only on the edge that closes an OKAY data phase
    assign w_we = ((r_state == ST_DATA) && r_write) ? r_mask : '0;

    sram_be_array #(
        .IDX_WIDTH  (IW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (HWDATA),
        .i_ridx  (r_idx),
        .o_rdata (w_rdata)
    );

    // Responses decoded from the state register
    assign w_rd_phase = ((r_state == ST_WAIT) || (r_state == ST_DATA)) && !r_write;
    assign HRDATA     = w_rd_phase ? w_rdata : '0;
    assign HREADYOUT  = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    assign HRESP      = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
